// File: rtl/seq_frame_tx_if.sv
// Handshake and serial-output bundle for the sync-preamble frame transmitter.
// The source side offers payload words; the transmitter side drives the serial stream.
interface seq_frame_tx_if #(
    parameter int PAYLOAD_W = 8
);
    logic                 load_valid;
    logic                 load_ready;
    logic [PAYLOAD_W-1:0] load_data;
    logic                 output_bit;
    logic                 bit_valid;
    logic                 frame_start;
    logic                 busy;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  output_bit,
        input  bit_valid,
        input  frame_start,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output output_bit,
        output bit_valid,
        output frame_start,
        output busy
    );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync preamble, payload MSB-first, then idle guard gap.
// All outputs come straight from flops so nothing on the bus is combinational from load_valid.
module seq_frame_tx #(
    parameter int             PAYLOAD_W  = 8,
    parameter int             PRE_W      = 5,
    parameter logic [PRE_W-1:0] PREAMBLE = 5'b10101,
    parameter int             GAP_CYCLES = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    seq_frame_tx_if.slave bus
);
    localparam int MAX_A  = (PRE_W > PAYLOAD_W) ? PRE_W : PAYLOAD_W;
    localparam int MAX_B  = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int MAX_C  = (MAX_B > 2) ? MAX_B : 2;
    localparam int CNT_W  = $clog2(MAX_C);
    localparam int GAP_LD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        PAY  = 2'd2,
        GAP  = 2'd3
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_m1;
    logic [PAYLOAD_W-1:0] shift_q;
    logic                 bit_q;
    logic                 valid_q;
    logic                 fs_q;
    logic                 busy_q;
    logic                 ready_q;

    assign cnt_m1 = cnt_q - 1'b1;

    // Output flops are loaded with the value for the state being entered, so they line up with state_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            fs_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load_valid) begin
                        state_q <= PRE;
                        cnt_q   <= CNT_W'(PRE_W - 1);
                        shift_q <= bus.load_data;
                        bit_q   <= PREAMBLE[PRE_W-1];
                        valid_q <= 1'b1;
                        fs_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                PRE: begin
                    if (cnt_q == '0) begin
                        state_q <= PAY;
                        cnt_q   <= CNT_W'(PAYLOAD_W - 1);
                        bit_q   <= shift_q[PAYLOAD_W-1];
                        shift_q <= shift_q << 1;
                    end else begin
                        cnt_q <= cnt_m1;
                        bit_q <= PREAMBLE[cnt_m1];
                    end
                end
                PAY: begin
                    if (cnt_q == '0) begin
                        bit_q   <= 1'b0;
                        valid_q <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= GAP;
                            cnt_q   <= CNT_W'(GAP_LD);
                        end
                    end else begin
                        cnt_q   <= cnt_m1;
                        bit_q   <= shift_q[PAYLOAD_W-1];
                        shift_q <= shift_q << 1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_m1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    bit_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ready  = ready_q;
    assign bus.output_bit  = bit_q;
    assign bus.bit_valid   = valid_q;
    assign bus.frame_start = fs_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: scoreboarded serial bits plus a behavioural 10101 detector on the stream.
module tb_seq_frame_tx;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic det_rst;

    seq_frame_tx_if #(.PAYLOAD_W(PW)) bus ();

    seq_frame_tx #(.PAYLOAD_W(PW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   fs_cyc  = -100;
    int   fs_cnt  = 0;
    int   hit_cnt = 0;
    bit   mon_det = 1'b0;
    logic exp_q[$];

    // Reference 10101 detector with an active-high reset.
    logic [4:0] det_sr;
    logic       det_hit;
    assign det_rst = ~rst_n;

    always_ff @(posedge clk or posedge det_rst) begin
        if (det_rst) begin
            det_sr  <= '0;
            det_hit <= 1'b0;
        end else begin
            det_sr  <= {det_sr[3:0], bus.output_bit};
            det_hit <= ({det_sr[3:0], bus.output_bit} == 5'b10101);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_frame(input logic [PW-1:0] d);
        logic [4:0] pre;
        pre = 5'b10101;
        for (int i = 4; i >= 0; i--) exp_q.push_back(pre[i]);
        for (int i = PW - 1; i >= 0; i--) exp_q.push_back(d[i]);
    endtask

    // Scoreboard consumer and detector monitor.
    always @(negedge clk) begin
        cyc++;
        if (bus.frame_start === 1'b1) begin
            fs_cyc = cyc;
            fs_cnt++;
        end
        if (bus.bit_valid === 1'b1) begin
            chk("sb_underflow", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("serial_bit", 32'(bus.output_bit), 32'(exp_q.pop_front()));
        end else begin
            chk("idle_bit_zero", 32'(bus.output_bit), 32'd0);
        end
        if (mon_det && det_hit === 1'b1) begin
            hit_cnt++;
            chk("det_hit_timing", 32'(cyc - fs_cyc), 32'd5);
        end
    end

    initial begin
        int n;
        int frames;
        int fsb;

        // Reset held with an offer pending
        rst_n          = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hA5;
        wait_neg(3);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
        chk("rst_output_bit", 32'(bus.output_bit), 32'd0);
        chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
        bus.load_valid = 1'b0;
        rst_n          = 1'b1;
        wait_neg(1);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        // Single frame A5; data changes after accept must not matter
        bus.load_data  = 8'hA5;
        bus.load_valid = 1'b1;
        push_frame(8'hA5);
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        chk("single_fs", 32'(bus.frame_start), 32'd1);
        chk("single_busy", 32'(bus.busy), 32'd1);
        chk("single_ready", 32'(bus.load_ready), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("single_fs_pulse", 32'(bus.frame_start), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("gap_bit_valid", 32'(bus.bit_valid), 32'd0);
            chk("gap_busy", 32'(bus.busy), 32'd1);
            chk("gap_ready", 32'(bus.load_ready), 32'd0);
        end
        @(negedge clk);
        chk("single_end_ready", 32'(bus.load_ready), 32'd1);
        chk("single_end_busy", 32'(bus.busy), 32'd0);
        chk("single_sb_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back FF then 00 with load_valid held
        bus.load_data  = 8'hFF;
        bus.load_valid = 1'b1;
        push_frame(8'hFF);
        @(negedge clk);
        chk("b2b_first_fs", 32'(bus.frame_start), 32'd1);
        bus.load_data = 8'h00;
        push_frame(8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_start !== 1'b1 && n < 20);
        bus.load_valid = 1'b0;
        chk("b2b_period", 32'(n), 32'd16);
        wait_neg(15);
        chk("b2b_end_ready", 32'(bus.load_ready), 32'd1);
        chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        // Offer during the 4th payload cycle is ignored
        bus.load_data  = 8'hC3;
        bus.load_valid = 1'b1;
        push_frame(8'hC3);
        @(negedge clk);
        bus.load_valid = 1'b0;
        wait_neg(8);
        chk("rej_busy", 32'(bus.busy), 32'd1);
        bus.load_data  = 8'h3C;
        bus.load_valid = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
        wait_neg(6);
        chk("rej_end_ready", 32'(bus.load_ready), 32'd1);
        fsb = fs_cnt;
        wait_neg(20);
        chk("rej_no_extra_frame", 32'(fs_cnt), 32'(fsb));
        chk("rej_idle_busy", 32'(bus.busy), 32'd0);
        chk("rej_sb_empty", 32'(exp_q.size()), 32'd0);

        // Async abort during the 3rd payload bit
        bus.load_data  = 8'h5A;
        bus.load_valid = 1'b1;
        push_frame(8'h5A);
        @(negedge clk);
        bus.load_valid = 1'b0;
        wait_neg(7);
        chk("abort_pre_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_bit_valid", 32'(bus.bit_valid), 32'd0);
        chk("abort_output_bit", 32'(bus.output_bit), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ready", 32'(bus.load_ready), 32'd1);
        exp_q.delete();
        wait_neg(2);
        rst_n          = 1'b1;
        bus.load_data  = 8'h81;
        bus.load_valid = 1'b1;
        push_frame(8'h81);
        @(negedge clk);
        bus.load_valid = 1'b0;
        chk("abort_restart_fs", 32'(bus.frame_start), 32'd1);
        wait_neg(15);
        chk("abort_end_ready", 32'(bus.load_ready), 32'd1);
        chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);

        // Loopback: 10 zero-payload frames into the detector
        hit_cnt = 0;
        mon_det = 1'b1;
        for (int i = 0; i < 10; i++) push_frame(8'h00);
        bus.load_data  = 8'h00;
        bus.load_valid = 1'b1;
        n      = 0;
        frames = 0;
        while (frames < 10 && n < 400) begin
            @(negedge clk);
            n++;
            if (bus.frame_start === 1'b1) frames++;
        end
        bus.load_valid = 1'b0;
        chk("loop_frames", 32'(frames), 32'd10);
        wait_neg(16);
        chk("loop_det_hits", 32'(hit_cnt), 32'd10);
        chk("loop_sb_empty", 32'(exp_q.size()), 32'd0);
        mon_det = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
